me_search_ctrl: RTL

- Sequences a full-search integer motion estimation pass for one 16x16 block over a square search window.
- Issues one candidate motion vector per cycle to the SAD tree and min-SAD comparator, and pulses the comparator's min-register clear at the start of each pass.
- Tracks the winning MV for each 16x16 SAD lane by aligning delayed candidate MVs with the returning SAD values.
- Sits between the top-level ME controller (start/done) and the SAD datapath.

---
 rtl/me_search_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/me_search_ctrl.sv
// Full-search integer motion estimation sequencer for one 16x16 block.
// Issues one candidate MV per cycle in raster order, clears the downstream
// min-SAD comparator at the start of each pass, and tracks the per-lane
// winning MV by aligning delayed candidates with the returning SADs.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        pulse; begins a pass when idle
//   stall        reference fetch not ready; holds candidate issue
//   sad16x16     NUM_PU SAD lanes, lane p at [p*SAD_W +: SAD_W]
//   cand_valid   candidate issued this cycle
//   cand_mvx/y   candidate MV (signed), held while cand_valid=0
//   cmp_clear    one-cycle clear of the comparator min registers
//   busy         FSM not idle
//   done         one-cycle pulse at pass completion
//   best_mvx/y   per-lane winning MV (signed)
//   best_sad     per-lane minimum SAD
module me_search_ctrl #(
  parameter int          RANGE   = 16,
  parameter int unsigned MV_W    = 6,
  parameter int unsigned SAD_W   = 16,
  parameter int unsigned NUM_PU  = 4,
  parameter int unsigned SAD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stall,
  input  logic [NUM_PU*SAD_W-1:0]  sad16x16,
  output logic                     cand_valid,
  output logic [MV_W-1:0]          cand_mvx,
  output logic [MV_W-1:0]          cand_mvy,
  output logic                     cmp_clear,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_PU*MV_W-1:0]   best_mvx,
  output logic [NUM_PU*MV_W-1:0]   best_mvy,
  output logic [NUM_PU*SAD_W-1:0]  best_sad
);

  localparam int unsigned CNT_W = (SAD_LAT > 1) ? $clog2(SAD_LAT) : 1;
  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-RANGE);
  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(RANGE - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SEARCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic            vld;
    logic [MV_W-1:0] mvx;
    logic [MV_W-1:0] mvy;
  } dl_t;

  state_t                   state_q, state_d;
  logic signed [MV_W-1:0]   mvx_q, mvx_d, mvy_q, mvy_d;
  logic [CNT_W-1:0]         drain_q, drain_d;
  logic                     cand_valid_q, cand_valid_d;
  logic [MV_W-1:0]          cand_mvx_q, cand_mvx_d, cand_mvy_q, cand_mvy_d;
  logic                     cmp_clear_q, cmp_clear_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [NUM_PU*MV_W-1:0]   best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;
  logic [NUM_PU*SAD_W-1:0]  best_sad_q, best_sad_d;
  dl_t                      dl_q [SAD_LAT];
  dl_t                      dl_d [SAD_LAT];
  dl_t                      sad_tag;

  // Delay line: realigns issued candidates with their SADs, shifts every cycle
  always_comb begin
    dl_d[0] = '{vld: cand_valid_q, mvx: cand_mvx_q, mvy: cand_mvy_q};
    for (int unsigned i = 1; i < SAD_LAT; i++) dl_d[i] = dl_q[i-1];
  end

  assign sad_tag = dl_q[SAD_LAT-1];

  // Next-state, candidate generation and best tracking
  always_comb begin
    state_d      = state_q;
    mvx_d        = mvx_q;
    mvy_d        = mvy_q;
    drain_d      = drain_q;
    cand_valid_d = 1'b0;
    cand_mvx_d   = cand_mvx_q;
    cand_mvy_d   = cand_mvy_q;
    best_sad_d   = best_sad_q;
    best_mvx_d   = best_mvx_q;
    best_mvy_d   = best_mvy_q;

    unique case (state_q)
      IDLE:   if (start) state_d = CLEAR;
      CLEAR: begin
        mvx_d   = MV_MIN;
        mvy_d   = MV_MIN;
        state_d = SEARCH;
      end
      SEARCH: if (!stall) begin
        cand_valid_d = 1'b1;
        cand_mvx_d   = mvx_q;
        cand_mvy_d   = mvy_q;
        if (mvx_q == MV_MAX) begin
          mvx_d = MV_MIN;
          if (mvy_q == MV_MAX) begin
            state_d = DRAIN;
            drain_d = CNT_W'(SAD_LAT - 1);
          end else begin
            mvy_d = mvy_q + MV_W'(1);
          end
        end else begin
          mvx_d = mvx_q + MV_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = DONE;
        else               drain_d = drain_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // done trails the DONE state by one cycle so the last SAD update is visible
    done_d      = (state_q == DONE);
    cmp_clear_d = (state_d == CLEAR);
    busy_d      = (state_d != IDLE);

    // CLEAR initialisation wins over any update in the same cycle
    if (state_q == CLEAR) begin
      best_sad_d = '1;
      best_mvx_d = '0;
      best_mvy_d = '0;
    end else if (sad_tag.vld) begin
      for (int unsigned p = 0; p < NUM_PU; p++) begin
        // strict less-than keeps the earliest candidate on ties
        if (sad16x16[p*SAD_W +: SAD_W] < best_sad_q[p*SAD_W +: SAD_W]) begin
          best_sad_d[p*SAD_W +: SAD_W] = sad16x16[p*SAD_W +: SAD_W];
          best_mvx_d[p*MV_W +: MV_W]   = sad_tag.mvx;
          best_mvy_d[p*MV_W +: MV_W]   = sad_tag.mvy;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mvx_q        <= '0;
      mvy_q        <= '0;
      drain_q      <= '0;
      cand_valid_q <= 1'b0;
      cand_mvx_q   <= '0;
      cand_mvy_q   <= '0;
      cmp_clear_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_sad_q   <= '1;
      best_mvx_q   <= '0;
      best_mvy_q   <= '0;
      for (int unsigned i = 0; i < SAD_LAT; i++) dl_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      mvx_q        <= mvx_d;
      mvy_q        <= mvy_d;
      drain_q      <= drain_d;
      cand_valid_q <= cand_valid_d;
      cand_mvx_q   <= cand_mvx_d;
      cand_mvy_q   <= cand_mvy_d;
      cmp_clear_q  <= cmp_clear_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      best_sad_q   <= best_sad_d;
      best_mvx_q   <= best_mvx_d;
      best_mvy_q   <= best_mvy_d;
      for (int unsigned i = 0; i < SAD_LAT; i++) dl_q[i] <= dl_d[i];
    end
  end

  assign cand_valid = cand_valid_q;
  assign cand_mvx   = cand_mvx_q;
  assign cand_mvy   = cand_mvy_q;
  assign cmp_clear  = cmp_clear_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_mvx   = best_mvx_q;
  assign best_mvy   = best_mvy_q;
  assign best_sad   = best_sad_q;

endmodule
